// File: rtl/pwm_rampa_motor.sv
// PWM motor driver with soft duty ramping.
// Takes the one-hot speed request from the ramp-start FSM and moves the applied
// duty toward it in STEP-percent increments. Duty only changes at a PWM period
// boundary, once every RAMP_PERIODS periods, so the motor current changes gradually.
//
// state    | meaning
// ---------+-----------------------------------------------
// REPOSO   | duty == 0 and target == 0, motor idle
// SUBIENDO | duty < target, ramping up
// BAJANDO  | duty > target, ramping down
// ESTABLE  | duty == target != 0, running at commanded speed
module pwm_rampa_motor #(
    parameter int PRESC        = 10,
    parameter int RAMP_PERIODS = 4,
    parameter int STEP         = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_30,
    input  logic       in_50,
    input  logic       in_100,
    output logic       pwm_out,
    output logic [6:0] duty,
    output logic [1:0] estado,
    output logic       at_target
);

    typedef enum logic [1:0] {
        REPOSO   = 2'b00,
        SUBIENDO = 2'b01,
        BAJANDO  = 2'b10,
        ESTABLE  = 2'b11
    } estado_t;

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
    localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_PERIODS - 1);
    localparam logic [7:0]    STEP8      = 8'(STEP);
    localparam logic [6:0]    PWM_LAST   = 7'd99;

    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    pwm_cnt_q, pwm_cnt_d;
    logic [RW-1:0] ramp_q, ramp_d;
    logic [6:0]    target_q, target_d;
    logic [6:0]    duty_q, duty_d;
    logic          pwm_q, pwm_d;

    logic          tick;
    logic          period_end;
    logic [7:0]    duty8, tgt8, up8, dn_floor8, dn8;
    estado_t       estado_c;

    // Speed request decode, highest level wins.
    always_comb begin
        target_d = 7'd0;
        if (in_100)
            target_d = 7'd100;
        else if (in_50)
            target_d = 7'd50;
        else if (in_30)
            target_d = 7'd30;
    end

    // Prescaler and PWM period counter.
    always_comb begin
        tick       = (presc_q == PRESC_LAST);
        period_end = tick && (pwm_cnt_q == PWM_LAST);
        presc_d    = tick ? '0 : presc_q + PW'(1);
        pwm_cnt_d  = pwm_cnt_q;
        if (tick)
            pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? 7'd0 : pwm_cnt_q + 7'd1;
    end

    // Ramp pacing and clamped duty step; 8-bit math keeps duty+STEP from wrapping.
    always_comb begin
        duty8     = {1'b0, duty_q};
        tgt8      = {1'b0, target_q};
        up8       = duty8 + STEP8;
        dn_floor8 = tgt8 + STEP8;
        dn8       = duty8 - STEP8;
        duty_d    = duty_q;
        ramp_d    = ramp_q;
        if (duty_q == target_q) begin
            ramp_d = '0;
        end else if (period_end) begin
            if (ramp_q == RAMP_LAST) begin
                ramp_d = '0;
                if (duty_q < target_q)
                    duty_d = (up8 >= tgt8) ? target_q : up8[6:0];
                else
                    duty_d = (duty8 <= dn_floor8) ? target_q : dn8[6:0];
            end else begin
                ramp_d = ramp_q + RW'(1);
            end
        end
    end

    // PWM compare, registered so the output to the power stage is glitch-free.
    always_comb begin
        pwm_d = (pwm_cnt_q < duty_q);
    end

    // Ramp state derived from applied duty versus registered target.
    always_comb begin
        estado_c = REPOSO;
        if (duty_q == target_q)
            estado_c = (duty_q == 7'd0) ? REPOSO : ESTABLE;
        else if (duty_q < target_q)
            estado_c = SUBIENDO;
        else
            estado_c = BAJANDO;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q   <= '0;
            pwm_cnt_q <= 7'd0;
            ramp_q    <= '0;
            target_q  <= 7'd0;
            duty_q    <= 7'd0;
            pwm_q     <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            ramp_q    <= ramp_d;
            target_q  <= target_d;
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm_out   = pwm_q;
    assign duty      = duty_q;
    assign estado    = estado_c;
    assign at_target = (duty_q == target_q);

endmodule

// File: tb/tb_pwm_rampa_motor.sv
// Self-checking bench for pwm_rampa_motor: three instances with different
// parameter sets; expected duty steps are queued when a request is driven and
// popped as the DUT changes duty.
module tb_pwm_rampa_motor;

    localparam logic [1:0] REPOSO   = 2'b00;
    localparam logic [1:0] SUBIENDO = 2'b01;
    localparam logic [1:0] BAJANDO  = 2'b10;
    localparam logic [1:0] ESTABLE  = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, i30_a, i50_a, i100_a, pwm_a, at_a;
    logic [6:0] duty_a;
    logic [1:0] est_a;
    logic       rst_b, i30_b, i50_b, i100_b, pwm_b, at_b;
    logic [6:0] duty_b;
    logic [1:0] est_b;
    logic       rst_c, i30_c, i50_c, i100_c, pwm_c, at_c;
    logic [6:0] duty_c;
    logic [1:0] est_c;

    pwm_rampa_motor #(.PRESC(1), .RAMP_PERIODS(1), .STEP(10)) dut_a (
        .clk(clk), .reset(rst_a), .in_30(i30_a), .in_50(i50_a), .in_100(i100_a),
        .pwm_out(pwm_a), .duty(duty_a), .estado(est_a), .at_target(at_a));

    pwm_rampa_motor #(.PRESC(1), .RAMP_PERIODS(1), .STEP(20)) dut_b (
        .clk(clk), .reset(rst_b), .in_30(i30_b), .in_50(i50_b), .in_100(i100_b),
        .pwm_out(pwm_b), .duty(duty_b), .estado(est_b), .at_target(at_b));

    pwm_rampa_motor #(.PRESC(10), .RAMP_PERIODS(4), .STEP(10)) dut_c (
        .clk(clk), .reset(rst_c), .in_30(i30_c), .in_50(i50_c), .in_100(i100_c),
        .pwm_out(pwm_c), .duty(duty_c), .estado(est_c), .at_target(at_c));

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int gap_q[$];

    function automatic logic [6:0] get_duty(input int s);
        return (s == 0) ? duty_a : (s == 1) ? duty_b : duty_c;
    endfunction
    function automatic logic [1:0] get_est(input int s);
        return (s == 0) ? est_a : (s == 1) ? est_b : est_c;
    endfunction
    function automatic logic get_pwm(input int s);
        return (s == 0) ? pwm_a : (s == 1) ? pwm_b : pwm_c;
    endfunction
    function automatic logic get_at(input int s);
        return (s == 0) ? at_a : (s == 1) ? at_b : at_c;
    endfunction

    task automatic wait_change(input int s, input int budget, output int clocks, output bit timeout);
        logic [6:0] old;
        old = get_duty(s);
        clocks = 0;
        timeout = 1'b1;
        while (timeout && clocks < budget) begin
            @(negedge clk);
            clocks++;
            if (get_duty(s) !== old) timeout = 1'b0;
        end
    endtask

    task automatic count_pwm(input int s, input int n, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (get_pwm(s) === 1'b1) hi++;
        end
    endtask

    // gap > 0: exact clocks between steps; gap < 0: only a budget of -gap clocks.
    task automatic drain(input int s, input string name);
        int exp_v, gap, clocks, budget;
        bit to;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            gap = gap_q.pop_front();
            budget = (gap > 0) ? gap + 5 : -gap;
            wait_change(s, budget, clocks, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL %s_step timeout waiting for duty %0d, duty stays %0d", name, exp_v, get_duty(s));
            end else if (get_duty(s) !== 7'(exp_v)) begin
                errors++;
                $display("FAIL %s_step duty got %0d expected %0d", name, get_duty(s), exp_v);
            end
            if (!to && gap > 0) begin
                checks++;
                if (clocks != gap) begin
                    errors++;
                    $display("FAIL %s_gap clocks got %0d expected %0d", name, clocks, gap);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_a = 1; rst_b = 1; rst_c = 1;
        i30_a = 0; i50_a = 0; i100_a = 0;
        i30_b = 0; i50_b = 0; i100_b = 0;
        i30_c = 0; i50_c = 0; i100_c = 0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (get_duty(s) !== 7'd0) begin errors++; $display("FAIL reset_duty dut%0d got %0d expected 0", s, get_duty(s)); end
            checks++;
            if (get_pwm(s) !== 1'b0) begin errors++; $display("FAIL reset_pwm dut%0d got %b expected 0", s, get_pwm(s)); end
            checks++;
            if (get_est(s) !== REPOSO) begin errors++; $display("FAIL reset_estado dut%0d got %b expected 00", s, get_est(s)); end
            checks++;
            if (get_at(s) !== 1'b1) begin errors++; $display("FAIL reset_at dut%0d got %b expected 1", s, get_at(s)); end
        end
        rst_a = 0; rst_b = 0; rst_c = 0;
    endtask

    task automatic test_ramp_up_30();
        int hi;
        i30_a = 1;
        exp_q.push_back(10); gap_q.push_back(-150);
        drain(0, "up30");
        checks++;
        if (est_a !== SUBIENDO || at_a !== 1'b0) begin
            errors++; $display("FAIL up30_mid estado/at got %b/%b expected 01/0", est_a, at_a);
        end
        exp_q.push_back(20); gap_q.push_back(100);
        exp_q.push_back(30); gap_q.push_back(100);
        drain(0, "up30");
        checks++;
        if (est_a !== ESTABLE || at_a !== 1'b1) begin
            errors++; $display("FAIL up30_end estado/at got %b/%b expected 11/1", est_a, at_a);
        end
        count_pwm(0, 100, hi);
        checks++;
        if (hi != 30) begin errors++; $display("FAIL up30_pwm high clocks got %0d expected 30", hi); end
    endtask

    task automatic test_raise_100();
        int hi;
        i100_a = 1;
        repeat (2) @(negedge clk);
        checks++;
        if (est_a !== SUBIENDO) begin errors++; $display("FAIL raise_estado got %b expected 01", est_a); end
        for (int v = 40; v <= 100; v += 10) begin
            exp_q.push_back(v); gap_q.push_back((v == 40) ? -150 : 100);
        end
        drain(0, "raise");
        count_pwm(0, 100, hi);
        checks++;
        if (hi != 100) begin errors++; $display("FAIL raise_pwm high clocks got %0d expected 100", hi); end
        checks++;
        if (est_a !== ESTABLE || at_a !== 1'b1) begin
            errors++; $display("FAIL raise_end estado/at got %b/%b expected 11/1", est_a, at_a);
        end
    endtask

    task automatic test_drop_all();
        int hi;
        i30_a = 0; i100_a = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (est_a !== BAJANDO) begin errors++; $display("FAIL drop_estado got %b expected 10", est_a); end
        for (int v = 90; v >= 0; v -= 10) begin
            exp_q.push_back(v); gap_q.push_back((v == 90) ? -150 : 100);
        end
        drain(0, "drop");
        checks++;
        if (est_a !== REPOSO || at_a !== 1'b1) begin
            errors++; $display("FAIL drop_end estado/at got %b/%b expected 00/1", est_a, at_a);
        end
        count_pwm(0, 100, hi);
        checks++;
        if (hi != 0) begin errors++; $display("FAIL drop_pwm high clocks got %0d expected 0", hi); end
    endtask

    task automatic test_clamp_step20();
        int clocks;
        bit to;
        i50_b = 1;
        exp_q.push_back(20); gap_q.push_back(-150);
        exp_q.push_back(40); gap_q.push_back(100);
        exp_q.push_back(50); gap_q.push_back(100);
        drain(1, "clamp");
        checks++;
        if (at_b !== 1'b1 || est_b !== ESTABLE) begin
            errors++; $display("FAIL clamp_end at/estado got %b/%b expected 1/11", at_b, est_b);
        end
        wait_change(1, 250, clocks, to);
        checks++;
        if (!to) begin errors++; $display("FAIL clamp_hold duty moved to %0d expected 50", duty_b); end
    endtask

    task automatic test_reversal();
        int hi;
        i100_a = 1;
        exp_q.push_back(10); gap_q.push_back(-150);
        for (int v = 20; v <= 60; v += 10) begin
            exp_q.push_back(v); gap_q.push_back(100);
        end
        drain(0, "rev_up");
        i100_a = 0; i30_a = 1;
        count_pwm(0, 100, hi);
        checks++;
        if (hi != 60) begin errors++; $display("FAIL rev_period high clocks got %0d expected 60", hi); end
        checks++;
        if (duty_a !== 7'd50 || est_a !== BAJANDO) begin
            errors++; $display("FAIL rev_first duty/estado got %0d/%b expected 50/10", duty_a, est_a);
        end
        exp_q.push_back(40); gap_q.push_back(100);
        exp_q.push_back(30); gap_q.push_back(100);
        drain(0, "rev_down");
        checks++;
        if (est_a !== ESTABLE || at_a !== 1'b1) begin
            errors++; $display("FAIL rev_end estado/at got %b/%b expected 11/1", est_a, at_a);
        end
    endtask

    task automatic test_reset_mid_ramp();
        i100_c = 1;
        exp_q.push_back(10); gap_q.push_back(-5100);
        exp_q.push_back(20); gap_q.push_back(4000);
        exp_q.push_back(30); gap_q.push_back(4000);
        exp_q.push_back(40); gap_q.push_back(4000);
        drain(2, "slow_up");
        repeat (37) @(negedge clk);
        rst_c = 1;
        @(negedge clk);
        rst_c = 0;
        checks++;
        if (duty_c !== 7'd0 || pwm_c !== 1'b0) begin
            errors++; $display("FAIL midrst_out duty/pwm got %0d/%b expected 0/0", duty_c, pwm_c);
        end
        checks++;
        if (est_c !== REPOSO || at_c !== 1'b1) begin
            errors++; $display("FAIL midrst_state estado/at got %b/%b expected 00/1", est_c, at_c);
        end
        exp_q.push_back(10); gap_q.push_back(4000);
        exp_q.push_back(20); gap_q.push_back(4000);
        drain(2, "restart");
    endtask

    initial begin
        test_reset();
        test_ramp_up_30();
        test_raise_100();
        test_drop_all();
        test_clamp_step20();
        test_reversal();
        test_reset_mid_ramp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_rampa_motor.md
Name: pwm_rampa_motor

Overview:
- Downstream stage of the ramp-start FSM. Consumes its one-hot speed levels (30 %, 50 %, 100 %) and drives the motor power stage with a PWM signal.
- Duty cycle never jumps. It slews toward the commanded level in fixed percent steps, and only at PWM period boundaries, so the motor current ramps softly both up and down.
- Also reports the current duty and the ramp state for status logic.

Parameters:
- PRESC, 10: clocks per PWM tick; legal range ≥1.
- RAMP_PERIODS, 4: PWM periods between successive duty steps; legal range ≥1.
- STEP, 5: duty increment or decrement per step, in percent; legal range 1..100.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset; one clock, all state sampled on rising edge of clk
- in_30  input  1  speed level 30 % request (from ramp FSM out_30)
- in_50  input  1  speed level 50 % request (from out_50)
- in_100  input  1  speed level 100 % request (from out_100)
- pwm_out  output  1  registered PWM drive to power stage
- duty  output  7  current applied duty in percent, 0..100
- estado  output  2  ramp state: 00 REPOSO, 01 SUBIENDO, 10 BAJANDO, 11 ESTABLE
- at_target  output  1  high when duty equals registered target

Behaviour:
- Reset (sync, high) clears every register:
  - Registers cleared: presc_cnt=0, pwm_cnt=0, ramp_cnt=0, target=0, duty=0.
  - Outputs after reset: pwm_out=0, estado=REPOSO, at_target=1.
  - Reset asserted mid-ramp forces the same values on the next edge. No step completes on that edge.
- Target register, updated every clock from the inputs, with 1-cycle latency:
  - in_100 → 100; else in_50 → 50; else in_30 → 30; else 0.
  - Priority 100 > 50 > 30 when several inputs are high.
- Prescaler:
  - presc_cnt counts 0..PRESC-1 and wraps.
  - tick = (presc_cnt == PRESC-1). With PRESC=1, tick is high every clock.
- PWM counter:
  - pwm_cnt advances on tick, 0..99, wrapping 99→0.
  - period_end = tick && pwm_cnt==99.
  - One PWM period = 100*PRESC clocks.
- PWM output:
  - pwm_out <= (pwm_cnt < duty), registered, 1-clock latency.
  - duty=0 gives constant 0; duty=100 gives constant 1. No glitches.
- Ramp counter:
  - Increments on period_end while duty != target.
  - When ramp_cnt == RAMP_PERIODS-1 at period_end, a step is applied and ramp_cnt returns to 0.
  - Held at 0 while duty == target.
- Step rule, applied only at a step event:
  - duty<target: duty <= min(duty+STEP, target).
  - duty>target: duty <= max(duty-STEP, target).
  - Never overshoots; arithmetic is done 8 bits wide to avoid wrap.
  - duty changes only at period_end, so the current period always completes with the old duty.
- Target change mid-ramp:
  - The direction reverses at the next step event.
  - ramp_cnt is not cleared.
  - An in-progress period is not truncated.
- State, combinational from registered duty and target:
  - REPOSO: duty==0 && target==0.
  - ESTABLE: duty==target != 0.
  - SUBIENDO: duty<target.
  - BAJANDO: duty>target.
- at_target = (duty == target).
- Transitions follow automatically from duty/target updates:
  - REPOSO → SUBIENDO on nonzero target.
  - SUBIENDO → ESTABLE when the clamped step reaches target.
  - ESTABLE → BAJANDO on a lower target.
  - BAJANDO → REPOSO when duty reaches 0 with target 0.
- Input pulses shorter than one clock are not supported. Targets that change and revert between step events have no effect beyond their registered value at the step.

Test Plan (PRESC=1, RAMP_PERIODS=1, STEP=10 unless noted):
1. Reset, then in_30=1 held.
   - Required: duty 0→10→20→30 at clocks ~100/200/300; estado SUBIENDO then ESTABLE; at_target=1 after third step; pwm_out high 30 of every 100 clocks.
2. From ESTABLE 30, raise in_100 (in_30 still high).
   - Required: target=100 by priority; duty 40..100 over 7 periods; then pwm_out constantly 1, estado ESTABLE.
3. Drop all inputs from duty 100.
   - Required: estado BAJANDO; duty falls 90..0 over 10 periods; then REPOSO; pwm_out constantly 0.
4. STEP=20, in_50 from reset.
   - Required: duty 20, 40, 50 (clamped, no 60); at_target=1.
5. Reversal: ramping to 100, switch to in_30 when duty=60.
   - Required: next step gives 50, then 40, then 30; estado BAJANDO then ESTABLE; current period completes with duty 60.
6. Assert reset one clock while duty=40, with PRESC=10 and RAMP_PERIODS=4.
   - Required: next edge gives duty=0, pwm_out=0, counters 0; ramp restarts from 0 with 4000-clock step spacing.
